// File: rtl/ysyx_22040931_ifu_bus.sv
// ---------------------------------------------------------------------------
// ysyx_22040931_ifu_bus
//
// Instruction-fetch bus unit. It takes one fetch request from the IF stage,
// issues one read on an AXI-lite style AR/R bus, and extracts the 32-bit
// instruction from the 64-bit beat. It then holds that instruction for IF/ID
// until the valid/ready handshake completes. At most one bus transaction is
// outstanding. A flush kills the current fetch, and any beat still owed by
// the bus is consumed and thrown away before a new address is issued.
//
// Ports
//   clock       : clock, all state on posedge
//   reset       : asynchronous, active-low reset
//   req_valid   : fetch request from IF
//   req_pc      : fetch address
//   req_ready   : request accepted this cycle (combinational)
//   flush       : redirect, kill current / in-flight fetch
//   resp_valid  : instruction available to IF/ID
//   resp_ready  : IF/ID consumes the response
//   resp_instr  : fetched instruction (0 on error)
//   resp_pc     : PC of resp_instr
//   resp_err    : bus error or misaligned PC
//   ar_valid    : read-address valid
//   ar_addr     : read address, 8-byte aligned
//   ar_ready    : bus accepts address
//   r_valid     : read data valid
//   r_data      : read data beat
//   r_resp      : 0 = OKAY, otherwise error
//   r_ready     : unit accepts read data
// ---------------------------------------------------------------------------
module ysyx_22040931_ifu_bus #(
    parameter int PC_W   = 64,
    parameter int DATA_W = 64,
    parameter int INST_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req_valid,
    input  logic [PC_W-1:0]   req_pc,
    output logic              req_ready,
    input  logic              flush,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [INST_W-1:0] resp_instr,
    output logic [PC_W-1:0]   resp_pc,
    output logic              resp_err,

    output logic              ar_valid,
    output logic [PC_W-1:0]   ar_addr,
    input  logic              ar_ready,

    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    output logic              r_ready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    logic [2:0]        state;
    logic [PC_W-1:0]   pc_q;
    // Set when a flush lands while the address is still waiting for ar_ready;
    // the address cannot be withdrawn, so the beat it produces must be dropped.
    logic              drop_q;
    logic [PC_W-1:0]   ar_addr_q;
    logic [INST_W-1:0] resp_instr_q;
    logic [PC_W-1:0]   resp_pc_q;
    logic              resp_err_q;

    logic              accept;
    logic              misaligned;
    logic              bus_err;

    // Pick the 32-bit half of the beat addressed by pc[2].
    function automatic logic [INST_W-1:0] select_instr(input logic upper,
                                                       input logic [DATA_W-1:0] beat);
        if (upper)
            return beat[2*INST_W-1:INST_W];
        return beat[INST_W-1:0];
    endfunction

    // reset is folded in so req_ready stays 0 while reset is asserted.
    assign req_ready  = reset && !flush &&
                        ((state == S_IDLE) || ((state == S_HOLD) && resp_ready));
    assign accept     = req_valid && req_ready;
    assign misaligned = (req_pc[1:0] != 2'b00);
    assign bus_err    = (r_resp != 2'b00);

    assign ar_valid   = (state == S_ADDR);
    assign ar_addr    = ar_addr_q;
    assign r_ready    = (state == S_DATA) || (state == S_DROP);
    assign resp_valid = (state == S_HOLD);
    assign resp_instr = resp_instr_q;
    assign resp_pc    = resp_pc_q;
    assign resp_err   = resp_err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            pc_q         <= '0;
            drop_q       <= 1'b0;
            ar_addr_q    <= '0;
            resp_instr_q <= '0;
            resp_pc_q    <= '0;
            resp_err_q   <= 1'b0;
        end else if (accept) begin
            // accept only happens in IDLE, or in HOLD while the response is
            // being consumed, so it takes precedence over the per-state moves.
            if (misaligned) begin
                state        <= S_HOLD;
                resp_instr_q <= '0;
                resp_pc_q    <= req_pc;
                resp_err_q   <= 1'b1;
            end else begin
                state     <= S_ADDR;
                pc_q      <= req_pc;
                ar_addr_q <= {req_pc[PC_W-1:3], 3'b000};
                drop_q    <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: ;
                S_ADDR: begin
                    if (ar_ready) begin
                        state  <= (drop_q || flush) ? S_DROP : S_DATA;
                        drop_q <= 1'b0;
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (flush) begin
                        // Beat arriving with the flush is consumed here; otherwise
                        // it is still owed and DROP waits for it.
                        state <= r_valid ? S_IDLE : S_DROP;
                    end else if (r_valid) begin
                        state        <= S_HOLD;
                        resp_pc_q    <= pc_q;
                        resp_err_q   <= bus_err;
                        resp_instr_q <= bus_err ? '0 : select_instr(pc_q[2], r_data);
                    end
                end
                S_DROP: begin
                    if (r_valid)
                        state <= S_IDLE;
                end
                S_HOLD: begin
                    if (flush || resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_22040931_ifu_bus.md
Name: ysyx_22040931_ifu_bus

Overview:
Instruction-fetch bus unit between the core's fetch port (fetch_enb/pc out, instr in) and a valid/ready read bus (AR/R channels, AXI-lite style). It accepts one fetch request from the IF stage and issues one bus read. It selects the 32-bit instruction from the returned 64-bit beat and presents it to IF/ID with a valid/ready handshake. It supports a single outstanding transaction, pipeline flush/redirect with discard of in-flight data, and error reporting.

Parameters:
PC_W, 64, width of PC and bus address
DATA_W, 64, bus read data width
INST_W, 32, instruction width

Ports:
clock  in  1  clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  fetch request from IF (fetch_enb)
req_pc  in  PC_W  fetch address
req_ready  out  1  request accepted this cycle
flush  in  1  redirect; kill current/in-flight fetch
resp_valid  out  1  instruction available to IF/ID
resp_ready  in  1  IF/ID consumes response
resp_instr  out  INST_W  fetched instruction
resp_pc  out  PC_W  PC of resp_instr
resp_err  out  1  bus error or misaligned PC
ar_valid  out  1  read-address valid
ar_addr  out  PC_W  read address, aligned to 8 bytes
ar_ready  in  1  bus accepts address
r_valid  in  1  read data valid
r_data  in  DATA_W  read data beat
r_resp  in  2  0 = OKAY; non-zero = error
r_ready  out  1  unit accepts data

Behaviour:
- Reset (reset=0, async): state IDLE, drop flag 0. All outputs are 0: req_ready, resp_valid, resp_instr, resp_pc, resp_err, ar_valid, ar_addr, r_ready. After reset release, req_ready=1 combinationally while in IDLE.
- States: IDLE, ADDR, DATA, HOLD, DROP. Registered PC, and a registered "drop" flag for the ADDR state.
- req_ready = !flush && (IDLE || (HOLD && resp_ready)). A request is accepted on req_valid && req_ready.
- Accept with req_pc[1:0] != 0 (misaligned): no bus access. Next cycle go to HOLD with resp_err=1, resp_instr=0, resp_pc=req_pc.
- Accept with aligned PC: latch the PC and go to ADDR. ar_valid=1 and ar_addr={pc[PC_W-1:3],3'b0} are registered, so they are first visible the cycle after acceptance.
- ADDR: hold ar_valid and ar_addr stable until ar_ready. On handshake go to DATA, or to DROP if the drop flag is set. flush in ADDR sets the drop flag; ar_valid is never withdrawn before its handshake.
- DATA: r_ready=1. On r_valid, capture resp_instr = pc[2] ? r_data[63:32] : r_data[31:0]. Set resp_err = (r_resp!=0); on error, resp_instr=0. Next state HOLD with resp_valid=1.
- flush in DATA with no r_valid in the same cycle: go to DROP.
- flush in DATA with r_valid in the same cycle: discard the beat and go to IDLE.
- DROP: r_ready=1. On r_valid, discard the data and go to IDLE; resp_valid stays 0.
- HOLD: resp_valid=1, with resp_instr, resp_pc and resp_err stable until resp_ready.
  - On resp_ready: go to IDLE, or start a new fetch if a request is accepted in the same cycle (back-to-back).
  - flush in HOLD: resp_valid drops next cycle and the state goes to IDLE. The response is not delivered, even if resp_ready is asserted in the same cycle.
- Priority: flush > response handshake > new request. No request is accepted in a flush cycle.
- Minimum latency with a zero-wait bus: request accepted at cycle N, AR handshake at N+1, R handshake at N+2, resp_valid at N+3.
- One transaction outstanding at most. A new AR is never issued before the previous R beat, including a dropped one, has been consumed.
- Reset mid-transaction: all state clears immediately. Responses for pre-reset requests are the bus side's concern.

Test Plan:
- Basic fetch: pc=0x80000000, ar_ready=1, r_data=0x00100073_00000413 in the next cycle → ar_addr=0x80000000, resp_valid at N+3, resp_instr=0x00000413, resp_pc=0x80000000, resp_err=0.
- Upper word plus backpressure: pc=0x80000004, same r_data, resp_ready held 0 for 3 cycles → resp_instr=0x00100073, stable while valid; req_ready=1 only in the cycle resp_ready=1.
- AR stall plus flush: ar_ready=0 for 4 cycles, flush pulsed in cycle 2 → ar_valid stays high and ar_addr is unchanged until the handshake; the R beat is consumed with r_ready=1; no resp_valid; next request accepted afterwards.
- Flush in DATA: flush while waiting for r_valid, r_valid arrives 2 cycles later → beat discarded; a subsequent fetch at 0x80000008 returns its own data, not stale data.
- Errors: r_resp=2 → resp_err=1, resp_instr=0. pc=0x80000002 → no ar_valid; resp_err=1 at N+1.
- Async reset: reset=0 asserted mid-DATA, between clock edges → all outputs 0 immediately; after release, req_ready=1 and the next fetch completes normally.
